// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal entry block: FSM states,
// digit/button indexing and the BCD accumulate helper.
package decimal_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned NUM_BUTTONS = 5;
    localparam int unsigned BTN_U       = 0;
    localparam int unsigned BTN_D       = 1;
    localparam int unsigned BTN_L       = 2;
    localparam int unsigned BTN_R       = 3;
    localparam int unsigned BTN_C       = 4;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // acc*10 + digit using shifts; inputs are bounded so 14 bits never overflow
    function automatic logic [13:0] mul10_add(input logic [13:0] acc, input logic [3:0] digit);
        return (acc << 3) + (acc << 1) + {10'd0, digit};
    endfunction

endpackage

// File: rtl/decimal_entry_if.sv
// Button inputs and display/value outputs of the decimal entry block.
interface decimal_entry_if;

    logic        btnU;
    logic        btnD;
    logic        btnL;
    logic        btnR;
    logic        btnC;
    logic [15:0] bcd_digits;
    logic [1:0]  cursor;
    logic [15:0] value;
    logic        busy;
    logic        value_valid;

    modport master (
        output btnU, btnD, btnL, btnR, btnC,
        input  bcd_digits, cursor, value, busy, value_valid
    );

    modport slave (
        input  btnU, btnD, btnL, btnR, btnC,
        output bcd_digits, cursor, value, busy, value_valid
    );

endinterface

// File: rtl/decimal_entry_button_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter,
// and a one-cycle pulse on each rising edge of the debounced level.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            pulse <= 1'b0;
            // Any cycle agreeing with the current level restarts the count
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                    pulse <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/decimal_entry.sv
// Five-button 4-digit BCD editor with commit-time conversion to a
// saturated binary value.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_VALUE       = 9999
) (
    input  logic            clk,
    input  logic            rst_n,
    decimal_entry_if.slave  bus
);

    localparam logic [15:0] MAX_V = 16'(MAX_VALUE);

    logic [NUM_BUTTONS-1:0]     raw;
    logic [NUM_BUTTONS-1:0]     pulse;
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0][3:0] snap;
    logic [1:0]                 cursor;
    logic [1:0]                 step;
    logic [13:0]                acc;
    logic [13:0]                acc_next;
    logic [15:0]                value;
    logic                       busy;
    logic                       value_valid;
    state_t                     state;

    assign raw[BTN_U] = bus.btnU;
    assign raw[BTN_D] = bus.btnD;
    assign raw[BTN_L] = bus.btnL;
    assign raw[BTN_R] = bus.btnR;
    assign raw[BTN_C] = bus.btnC;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .pulse (pulse[i])
        );
    end

    assign acc_next = mul10_add(acc, snap[2'd3 - step]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            digits      <= '0;
            snap        <= '0;
            cursor      <= '0;
            step        <= '0;
            acc         <= '0;
            value       <= '0;
            busy        <= 1'b0;
            value_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse[BTN_C]) begin
                        snap  <= digits;
                        acc   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end else if (pulse[BTN_U]) begin
                        digits[cursor] <= (digits[cursor] == BCD_MAX) ? 4'd0 : digits[cursor] + 4'd1;
                    end else if (pulse[BTN_D]) begin
                        digits[cursor] <= (digits[cursor] == 4'd0) ? BCD_MAX : digits[cursor] - 4'd1;
                    end else if (pulse[BTN_L]) begin
                        if (cursor != 2'd3) cursor <= cursor + 2'd1;
                    end else if (pulse[BTN_R]) begin
                        if (cursor != 2'd0) cursor <= cursor - 2'd1;
                    end
                end
                CONVERT: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    // Saturated value is registered on entry to DONE so it is visible with value_valid
                    if (step == 2'd3) begin
                        value       <= ({2'b00, acc_next} > MAX_V) ? MAX_V : {2'b00, acc_next};
                        value_valid <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    value_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bcd_digits  = digits;
    assign bus.cursor      = cursor;
    assign bus.value       = value;
    assign bus.busy        = busy;
    assign bus.value_valid = value_valid;

endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry: two instances (MAX_VALUE 9999 and 360)
// share the same button stimulus.
module tb_decimal_entry;
    import decimal_entry_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    decimal_entry_if if_a ();
    decimal_entry_if if_b ();

    assign if_a.btnU = btn_u;
    assign if_a.btnD = btn_d;
    assign if_a.btnL = btn_l;
    assign if_a.btnR = btn_r;
    assign if_a.btnC = btn_c;
    assign if_b.btnU = btn_u;
    assign if_b.btnD = btn_d;
    assign if_b.btnL = btn_l;
    assign if_b.btnR = btn_r;
    assign if_b.btnC = btn_c;

    decimal_entry #(.DEBOUNCE_CYCLES(4), .MAX_VALUE(9999)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    decimal_entry #(.DEBOUNCE_CYCLES(4), .MAX_VALUE(360)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    task automatic drive_btn(input int unsigned b, input logic v);
        case (b)
            BTN_U:   btn_u = v;
            BTN_D:   btn_d = v;
            BTN_L:   btn_l = v;
            BTN_R:   btn_r = v;
            default: btn_c = v;
        endcase
    endtask

    task automatic press(input int unsigned b);
        drive_btn(b, 1'b1);
        repeat (10) @(negedge clk);
        drive_btn(b, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic enter(input int unsigned d3, input int unsigned d2, input int unsigned d1, input int unsigned d0);
        do_reset();
        repeat (d0) press(BTN_U);
        press(BTN_L);
        repeat (d1) press(BTN_U);
        press(BTN_L);
        repeat (d2) press(BTN_U);
        press(BTN_L);
        repeat (d3) press(BTN_U);
    endtask

    // Raw C rises at n=0; optionally raw U rises at n=2 so its pulse lands while busy
    task automatic commit(input bit with_u, output int unsigned busy_at,
                          output int unsigned valid_at, output int unsigned valid_cnt);
        busy_at = 0;
        valid_at = 0;
        valid_cnt = 0;
        btn_c = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 2 && with_u) btn_u = 1'b1;
            if (n == 10) btn_c = 1'b0;
            if (n == 12) btn_u = 1'b0;
            if (if_a.busy && busy_at == 0) busy_at = n;
            if (if_a.value_valid) begin
                if (valid_at == 0) valid_at = n;
                valid_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (if_a.bcd_digits !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", if_a.bcd_digits); end
        total++; if (if_a.cursor !== 2'd0) begin bad++; $display("FAIL reset_cursor got=%0d exp=0", if_a.cursor); end
        total++; if (if_a.value !== 16'd0) begin bad++; $display("FAIL reset_value got=%0d exp=0", if_a.value); end
        total++; if ({if_a.busy, if_a.value_valid} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {if_a.busy, if_a.value_valid}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_debounce();
        btn_u = 1'b1;
        repeat (3) @(negedge clk);
        btn_u = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (if_a.bcd_digits !== 16'h0000) begin bad++; $display("FAIL short_press got=%h exp=0000", if_a.bcd_digits); end
        press(BTN_U);
        total++; if (if_a.bcd_digits !== 16'h0001) begin bad++; $display("FAIL long_press got=%h exp=0001", if_a.bcd_digits); end
    endtask

    task automatic test_digit_wrap();
        do_reset();
        repeat (9) press(BTN_U);
        total++; if (if_a.bcd_digits !== 16'h0009) begin bad++; $display("FAIL up_to_9 got=%h exp=0009", if_a.bcd_digits); end
        press(BTN_U);
        total++; if (if_a.bcd_digits !== 16'h0000) begin bad++; $display("FAIL wrap_up got=%h exp=0000", if_a.bcd_digits); end
        press(BTN_D);
        total++; if (if_a.bcd_digits !== 16'h0009) begin bad++; $display("FAIL wrap_down got=%h exp=0009", if_a.bcd_digits); end
        press(BTN_R);
        total++; if (if_a.cursor !== 2'd0) begin bad++; $display("FAIL cursor_floor got=%0d exp=0", if_a.cursor); end
        repeat (5) press(BTN_L);
        total++; if (if_a.cursor !== 2'd3) begin bad++; $display("FAIL cursor_ceil got=%0d exp=3", if_a.cursor); end
        total++; if (if_a.bcd_digits !== 16'h0009) begin bad++; $display("FAIL digits_after_moves got=%h exp=0009", if_a.bcd_digits); end
    endtask

    task automatic test_commit();
        int unsigned busy_at, valid_at, valid_cnt;
        enter(1, 2, 3, 4);
        total++; if (if_a.bcd_digits !== 16'h1234) begin bad++; $display("FAIL enter_1234 got=%h exp=1234", if_a.bcd_digits); end
        commit(1'b0, busy_at, valid_at, valid_cnt);
        total++; if (busy_at !== 7) begin bad++; $display("FAIL busy_rise got=%0d exp=7", busy_at); end
        total++; if (valid_at !== 11) begin bad++; $display("FAIL valid_latency got=%0d exp=11", valid_at); end
        total++; if (valid_cnt !== 1) begin bad++; $display("FAIL valid_width got=%0d exp=1", valid_cnt); end
        total++; if (if_a.value !== 16'd1234) begin bad++; $display("FAIL value_1234 got=%0d exp=1234", if_a.value); end
        total++; if (if_b.value !== 16'd360) begin bad++; $display("FAIL sat_1234 got=%0d exp=360", if_b.value); end
        total++; if (if_a.busy !== 1'b0) begin bad++; $display("FAIL busy_fall got=%b exp=0", if_a.busy); end
    endtask

    task automatic test_saturation();
        int unsigned busy_at, valid_at, valid_cnt;
        enter(0, 9, 9, 9);
        commit(1'b0, busy_at, valid_at, valid_cnt);
        total++; if (if_a.value !== 16'd999) begin bad++; $display("FAIL value_999 got=%0d exp=999", if_a.value); end
        total++; if (if_b.value !== 16'd360) begin bad++; $display("FAIL sat_999 got=%0d exp=360", if_b.value); end
        enter(0, 3, 6, 0);
        commit(1'b0, busy_at, valid_at, valid_cnt);
        total++; if (if_b.value !== 16'd360) begin bad++; $display("FAIL sat_360 got=%0d exp=360", if_b.value); end
        enter(0, 3, 5, 9);
        commit(1'b0, busy_at, valid_at, valid_cnt);
        total++; if (if_b.value !== 16'd359) begin bad++; $display("FAIL sat_359 got=%0d exp=359", if_b.value); end
    endtask

    task automatic test_busy_drop();
        int unsigned busy_at, valid_at, valid_cnt;
        enter(0, 0, 0, 5);
        commit(1'b1, busy_at, valid_at, valid_cnt);
        total++; if (if_a.bcd_digits !== 16'h0005) begin bad++; $display("FAIL edit_while_busy got=%h exp=0005", if_a.bcd_digits); end
        total++; if (if_a.value !== 16'd5) begin bad++; $display("FAIL value_while_busy got=%0d exp=5", if_a.value); end
        press(BTN_R);
        btn_u = 1'b1;
        btn_l = 1'b1;
        repeat (10) @(negedge clk);
        btn_u = 1'b0;
        btn_l = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (if_a.bcd_digits !== 16'h0105) begin bad++; $display("FAIL u_over_l_digits got=%h exp=0105", if_a.bcd_digits); end
        total++; if (if_a.cursor !== 2'd2) begin bad++; $display("FAIL u_over_l_cursor got=%0d exp=2", if_a.cursor); end
    endtask

    task automatic test_reset_mid();
        int unsigned busy_at, valid_at, valid_cnt;
        int unsigned late_valid;
        enter(0, 0, 1, 2);
        commit(1'b0, busy_at, valid_at, valid_cnt);
        total++; if (if_a.value !== 16'd12) begin bad++; $display("FAIL value_12 got=%0d exp=12", if_a.value); end
        btn_c = 1'b1;
        repeat (9) @(negedge clk);
        btn_c = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if ({if_a.bcd_digits, if_a.cursor, if_a.value, if_a.busy, if_a.value_valid} !== 36'd0)
            begin bad++; $display("FAIL mid_reset bcd=%h cur=%0d val=%0d busy=%b vv=%b exp=all 0",
                if_a.bcd_digits, if_a.cursor, if_a.value, if_a.busy, if_a.value_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        late_valid = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (if_a.value_valid || if_a.busy) late_valid++;
        end
        total++; if (late_valid !== 0) begin bad++; $display("FAIL no_valid_after_reset got=%0d exp=0", late_valid); end
        total++; if (if_a.value !== 16'd0) begin bad++; $display("FAIL value_after_reset got=%0d exp=0", if_a.value); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_digit_wrap();
        test_commit();
        test_saturation();
        test_busy_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
